// File: rtl/multi_timer.sv
// multi_timer: free-running cycle counter feeding CHANNELS compare channels with W1C pending flags,
// interrupt masking and a tristate read bus. Define MULTI_TIMER_PERIODIC_EN for PERIOD/auto-reload.
module multi_timer #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'hffff0100
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         data,
    input  logic [31:0]         address,
    input  logic                MemRead,
    input  logic                MemWrite,
    output logic [31:0]         rdata,
    output logic                TimerAddress,
    output logic                TimerInterrupt,
    output logic [CHANNELS-1:0] pending
);

    localparam logic [4:0] WORD_COUNT  = 5'd0;
    localparam logic [4:0] WORD_CTRL   = 5'd1;
    localparam logic [4:0] WORD_STATUS = 5'd2;
    localparam logic [4:0] WORD_CMP    = 5'd8;
    localparam logic [4:0] WORD_PER    = 5'd16;

    logic [WIDTH-1:0]    count_r;
    logic [WIDTH-1:0]    compare_r [CHANNELS];
    logic [WIDTH-1:0]    period_s  [CHANNELS];
    logic [WIDTH-1:0]    reload_s  [CHANNELS];
    logic [CHANNELS-1:0] enable_r;
    logic [CHANNELS-1:0] periodic_s;
    logic [CHANNELS-1:0] pending_r;
    logic [CHANNELS-1:0] match_s;
    logic [CHANNELS-1:0] clr_s;
    logic [CHANNELS-1:0] cmp_sel_s;
    logic [CHANNELS-1:0] per_sel_s;
    logic                in_window_s;
    logic [4:0]          word_s;
    logic                hit_s;
    logic                ctrl_sel_s;
    logic                status_sel_s;
    logic                wr_en_s;
    logic                wr_ctrl_s;
    logic                wr_status_s;
    logic [31:0]         rd_val_s;
    logic                unused_s;

    assign in_window_s = (address[31:7] == BASE_ADDR[31:7]) && (address[1:0] == 2'b00);
    assign word_s      = address[6:2];

    // Address decode and read-data mux over the 128-byte window
    always_comb begin
        hit_s        = 1'b0;
        ctrl_sel_s   = 1'b0;
        status_sel_s = 1'b0;
        cmp_sel_s    = '0;
        per_sel_s    = '0;
        rd_val_s     = 32'h0000_0000;
        if (in_window_s) begin
            case (word_s)
                WORD_COUNT: begin
                    hit_s                = 1'b1;
                    rd_val_s[WIDTH-1:0]  = count_r;
                end
                WORD_CTRL: begin
                    hit_s                   = 1'b1;
                    ctrl_sel_s              = 1'b1;
                    rd_val_s[CHANNELS-1:0]  = enable_r;
                    rd_val_s[8 +: CHANNELS] = periodic_s;
                end
                WORD_STATUS: begin
                    hit_s                  = 1'b1;
                    status_sel_s           = 1'b1;
                    rd_val_s[CHANNELS-1:0] = pending_r;
                end
                default: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        cmp_sel_s[i] = (word_s == (WORD_CMP + 5'(i)));
                        per_sel_s[i] = (word_s == (WORD_PER + 5'(i)));
                        rd_val_s[WIDTH-1:0] = rd_val_s[WIDTH-1:0]
                                            | (compare_r[i] & {WIDTH{cmp_sel_s[i]}})
                                            | (period_s[i]  & {WIDTH{per_sel_s[i]}});
                    end
                    hit_s = (|cmp_sel_s) | (|per_sel_s);
                end
            endcase
        end else begin
            hit_s = 1'b0;
        end
    end

    assign wr_en_s     = MemWrite && hit_s;
    assign wr_ctrl_s   = wr_en_s && ctrl_sel_s;
    assign wr_status_s = wr_en_s && status_sel_s;

    // Per-channel match against the registered count, plus W1C clear mask
    always_comb begin
        match_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            match_s[i] = (count_r == compare_r[i]);
        end
        if (wr_status_s) begin
            clr_s = data[CHANNELS-1:0];
        end else begin
            clr_s = '0;
        end
    end

`ifdef MULTI_TIMER_PERIODIC_EN
    logic [WIDTH-1:0]    period_r [CHANNELS];
    logic [CHANNELS-1:0] periodic_r;

    // PERIOD registers and periodic-mode bits
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            periodic_r <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                period_r[i] <= '0;
            end
        end else begin
            if (wr_ctrl_s) begin
                periodic_r <= data[8 +: CHANNELS];
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en_s && per_sel_s[i]) begin
                    period_r[i] <= data[WIDTH-1:0];
                end
            end
        end
    end

    // Auto-reload target; a zero period leaves COMPARE where it is
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            period_s[i] = period_r[i];
            reload_s[i] = periodic_r[i] ? (compare_r[i] + period_r[i]) : compare_r[i];
        end
    end

    assign periodic_s = periodic_r;
`else
    // One-shot build: COMPARE holds after a match, PERIOD reads as zero
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            period_s[i] = '0;
            reload_s[i] = compare_r[i];
        end
    end

    assign periodic_s = '0;
`endif

    // Counter, enables, pending flags and compare registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r   <= '0;
            enable_r  <= '0;
            pending_r <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                compare_r[i] <= '1;
            end
        end else begin
            count_r   <= count_r + WIDTH'(1'b1);
            pending_r <= (pending_r & ~clr_s) | match_s;
            if (wr_ctrl_s) begin
                enable_r <= data[CHANNELS-1:0];
            end
            // A software write beats a same-edge reload
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en_s && cmp_sel_s[i]) begin
                    compare_r[i] <= data[WIDTH-1:0];
                end else if (match_s[i]) begin
                    compare_r[i] <= reload_s[i];
                end
            end
        end
    end

    assign pending        = pending_r;
    assign TimerInterrupt = |(pending_r & enable_r);
    assign TimerAddress   = hit_s;
    assign rdata          = (MemRead && hit_s) ? rd_val_s : 32'bz;

    assign unused_s = ^{data, address, per_sel_s};

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: a 32-bit/4-channel instance checked against a cycle-level reference
// model, and an 8-bit/2-channel instance for counter wrap and window-boundary decode.
module tb_multi_timer;

    localparam logic [31:0] BASE32 = 32'hffff0100;
    localparam logic [31:0] BASE8  = 32'hffff0200;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data = 32'h0;
    logic [31:0] address = 32'h0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    wire  [31:0] rdata32;
    wire  [31:0] rdata8;
    logic        taddr32, irq32, taddr8, irq8;
    logic [3:0]  pend32;
    logic [1:0]  pend8;

    int checks = 0;
    int errors = 0;

    // reference model state (32-bit / 4-channel instance)
    logic [31:0] m_count;
    logic [31:0] m_cmp [4];
    logic [31:0] m_per [4];
    logic [3:0]  m_en, m_prd, m_pend;

    always #5 clk = ~clk;

    multi_timer #(.CHANNELS(4), .WIDTH(32), .BASE_ADDR(BASE32)) u_dut32 (
        .clock(clk), .reset(reset_n), .data(data), .address(address),
        .MemRead(mem_read), .MemWrite(mem_write), .rdata(rdata32),
        .TimerAddress(taddr32), .TimerInterrupt(irq32), .pending(pend32));

    multi_timer #(.CHANNELS(2), .WIDTH(8), .BASE_ADDR(BASE8)) u_dut8 (
        .clock(clk), .reset(reset_n), .data(data), .address(address),
        .MemRead(mem_read), .MemWrite(mem_write), .rdata(rdata8),
        .TimerAddress(taddr8), .TimerInterrupt(irq8), .pending(pend8));

    task automatic model_reset();
        m_count = 32'h0;
        m_en = 4'h0; m_prd = 4'h0; m_pend = 4'h0;
        for (int i = 0; i < 4; i++) begin
            m_cmp[i] = 32'hffff_ffff;
            m_per[i] = 32'h0;
        end
    endtask

    // One rising edge of the 32-bit timer, applying the bus operation present at that edge.
    task automatic model_edge();
        logic [3:0]  hit;
        logic [31:0] nc [4];
        int          w;
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            hit[i] = (m_count == m_cmp[i]);
            nc[i]  = (hit[i] && m_prd[i]) ? m_cmp[i] + m_per[i] : m_cmp[i];
        end
        if (mem_write && address[31:7] == BASE32[31:7] && address[1:0] == 2'b00) begin
            w = int'(address[6:2]);
            if (w == 1) begin
                m_en = data[3:0];
`ifdef MULTI_TIMER_PERIODIC_EN
                m_prd = data[11:8];
`endif
            end else if (w == 2) begin
                m_pend = m_pend & ~data[3:0];
            end else if (w >= 8 && w < 12) begin
                nc[w-8] = data;
            end else if (w >= 16 && w < 20) begin
`ifdef MULTI_TIMER_PERIODIC_EN
                m_per[w-16] = data;
`endif
            end
        end
        m_pend = m_pend | hit;
        for (int i = 0; i < 4; i++) m_cmp[i] = nc[i];
        m_count = m_count + 32'd1;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, output logic hit);
        int w;
        hit = 1'b0;
        model_read = 32'h0;
        if (a[31:7] == BASE32[31:7] && a[1:0] == 2'b00) begin
            w = int'(a[6:2]);
            if (w == 0) begin hit = 1'b1; model_read = m_count; end
            else if (w == 1) begin hit = 1'b1; model_read = {20'h0, m_prd, 4'h0, m_en}; end
            else if (w == 2) begin hit = 1'b1; model_read = {28'h0, m_pend}; end
            else if (w >= 8 && w < 12) begin hit = 1'b1; model_read = m_cmp[w-8]; end
            else if (w >= 16 && w < 20) begin hit = 1'b1; model_read = m_per[w-16]; end
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        address = a; data = d; mem_write = 1'b1;
        cycle();
        mem_write = 1'b0; address = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] v32, output logic t32,
                            output logic [31:0] v8, output logic t8);
        address = a; mem_read = 1'b1;
        #1;
        v32 = rdata32; t32 = taddr32; v8 = rdata8; t8 = taddr8;
        mem_read = 1'b0; address = 32'h0;
    endtask

    task automatic apply_reset(input int n);
        reset_n = 1'b0;
        model_reset();
        repeat (n) cycle();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] v, v8; logic t, t8;
        model_reset();
        repeat (3) cycle();
        bus_read(BASE32 + 32'h00, v, t, v8, t8);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_count got %h exp %h", v, 32'h0); end
        bus_read(BASE32 + 32'h20, v, t, v8, t8);
        checks++; if (v !== 32'hffff_ffff) begin errors++; $display("FAIL reset_compare0 got %h exp ffffffff", v); end
        bus_read(BASE8 + 32'h20, v, t, v8, t8);
        checks++; if (v8 !== 32'h0000_00ff) begin errors++; $display("FAIL reset_compare0_w8 got %h exp 000000ff", v8); end
        checks++; if (irq32 !== 1'b0 || pend32 !== 4'h0) begin errors++; $display("FAIL reset_irq got %b/%h exp 0/0", irq32, pend32); end
        reset_n = 1'b1;
        repeat (5) cycle();
        bus_read(BASE32 + 32'h00, v, t, v8, t8);
        checks++; if (v !== 32'd5) begin errors++; $display("FAIL count_after_5 got %0d exp 5", v); end
        // asynchronous reset in the middle of a cycle with an interrupt pending
        bus_write(BASE32 + 32'h04, 32'h1);
        bus_write(BASE32 + 32'h20, 32'd10);
        repeat (5) cycle();
        checks++; if (irq32 !== 1'b1) begin errors++; $display("FAIL pre_async_irq got %b exp 1", irq32); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (irq32 !== 1'b0 || pend32 !== 4'h0) begin errors++; $display("FAIL async_reset_irq got %b/%h exp 0/0", irq32, pend32); end
        bus_read(BASE32 + 32'h00, v, t, v8, t8);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL async_reset_count got %h exp 0", v); end
        model_reset();
        repeat (2) cycle();
        reset_n = 1'b1;
    endtask

    task automatic test_oneshot();
        logic [31:0] v, v8; logic t, t8;
        apply_reset(3);
        bus_write(BASE32 + 32'h04, 32'h1);
        bus_write(BASE32 + 32'h20, 32'd20);
        for (int k = 0; k < 100 && m_count != 32'd40; k++) begin
            if (m_count == 32'd21) begin
                checks++; if (irq32 !== 1'b1) begin errors++; $display("FAIL oneshot_irq_rise got %b exp 1", irq32); end
                bus_read(BASE32 + 32'h08, v, t, v8, t8);
                checks++; if (v !== 32'h1) begin errors++; $display("FAIL oneshot_status got %h exp 1", v); end
                bus_write(BASE32 + 32'h08, 32'h1);
            end else begin
                cycle();
            end
            checks++;
            if (irq32 !== (m_count == 32'd21)) begin
                errors++; $display("FAIL oneshot_irq count=%0d got %b exp %b", m_count, irq32, m_count == 32'd21);
            end
        end
    endtask

    task automatic test_periodic();
        logic [31:0] v, v8; logic t, t8;
        apply_reset(2);
`ifdef MULTI_TIMER_PERIODIC_EN
        bus_write(BASE32 + 32'h48, 32'd10);
        bus_write(BASE32 + 32'h28, 32'd30);
        bus_write(BASE32 + 32'h04, 32'h404);
        for (int k = 0; k < 100 && m_count != 32'd55; k++) begin
            if (m_count == 32'd40) begin
                checks++; if (pend32[2] !== 1'b0) begin errors++; $display("FAIL periodic_early got %b exp 0", pend32[2]); end
            end
            if (m_count == 32'd31 || m_count == 32'd41 || m_count == 32'd51) begin
                checks++; if (pend32[2] !== 1'b1 || irq32 !== 1'b1) begin
                    errors++; $display("FAIL periodic_set count=%0d got %b/%b exp 1/1", m_count, pend32[2], irq32);
                end
                bus_write(BASE32 + 32'h08, 32'h4);
            end else begin
                cycle();
            end
        end
        bus_read(BASE32 + 32'h28, v, t, v8, t8);
        checks++; if (v !== 32'd60) begin errors++; $display("FAIL periodic_compare got %0d exp 60", v); end
`else
        bus_write(BASE32 + 32'h48, 32'd10);
        bus_read(BASE32 + 32'h48, v, t, v8, t8);
        checks++; if (v !== 32'h0 || t !== 1'b1) begin errors++; $display("FAIL period_absent got %h/%b exp 0/1", v, t); end
        bus_write(BASE32 + 32'h04, 32'h404);
        bus_read(BASE32 + 32'h04, v, t, v8, t8);
        checks++; if (v !== 32'h4) begin errors++; $display("FAIL ctrl_no_periodic got %h exp 4", v); end
        bus_write(BASE32 + 32'h28, 32'd30);
        repeat (40) cycle();
        bus_read(BASE32 + 32'h28, v, t, v8, t8);
        checks++; if (v !== 32'd30 || pend32[2] !== 1'b1) begin errors++; $display("FAIL oneshot_hold got %0d/%b exp 30/1", v, pend32[2]); end
`endif
    endtask

    task automatic test_masked();
        logic [31:0] v, v8; logic t, t8;
        apply_reset(2);
        bus_write(BASE32 + 32'h04, 32'h0);
        bus_write(BASE32 + 32'h24, 32'd15);
        for (int k = 0; k < 50 && m_count != 32'd17; k++) begin
            cycle();
            checks++; if (irq32 !== 1'b0) begin errors++; $display("FAIL masked_irq count=%0d got %b exp 0", m_count, irq32); end
        end
        bus_read(BASE32 + 32'h08, v, t, v8, t8);
        checks++; if (v !== 32'h2) begin errors++; $display("FAIL masked_status got %h exp 2", v); end
        bus_write(BASE32 + 32'h04, 32'h2);
        checks++; if (irq32 !== 1'b1) begin errors++; $display("FAIL unmask_irq got %b exp 1", irq32); end
    endtask

    task automatic test_collision();
        logic [31:0] v, v8; logic t, t8;
        apply_reset(2);
`ifdef MULTI_TIMER_PERIODIC_EN
        bus_write(BASE32 + 32'h44, 32'd7);
        bus_write(BASE32 + 32'h04, 32'h201);
`else
        bus_write(BASE32 + 32'h04, 32'h1);
`endif
        bus_write(BASE32 + 32'h20, 32'd20);
        bus_write(BASE32 + 32'h24, 32'd25);
        for (int k = 0; k < 50 && m_count != 32'd20; k++) cycle();
        bus_write(BASE32 + 32'h08, 32'h1);
        checks++; if (pend32[0] !== 1'b1 || irq32 !== 1'b1) begin errors++; $display("FAIL collision_clear got %b/%b exp 1/1", pend32[0], irq32); end
        for (int k = 0; k < 50 && m_count != 32'd25; k++) cycle();
        bus_write(BASE32 + 32'h24, 32'd100);
        bus_read(BASE32 + 32'h24, v, t, v8, t8);
        checks++; if (v !== 32'd100 || pend32[1] !== 1'b1) begin errors++; $display("FAIL collision_compare got %0d/%b exp 100/1", v, pend32[1]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] c;
        apply_reset(2);
        for (int r = 0; r < 4; r++) begin
            bus_write(BASE32 + 32'h08, 32'h8);
            repeat ($urandom_range(1, 5)) cycle();
            c = m_count;
            bus_write(BASE32 + 32'h2c, c + 32'd1);
            checks++; if (pend32[3] !== 1'b0) begin errors++; $display("FAIL b2b_early got %b exp 0", pend32[3]); end
            cycle();
            checks++; if (pend32[3] !== 1'b1) begin errors++; $display("FAIL b2b_match got %b exp 1", pend32[3]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] v, v8, e; logic t, t8, h;
        int op;
        apply_reset(2);
        for (int k = 0; k < 1500; k++) begin
            op = $urandom_range(0, 9);
            case (op)
                0: bus_write(BASE32 + 32'h04, $urandom);
                1: bus_write(BASE32 + 32'h08, $urandom);
                2, 3: bus_write(BASE32 + 32'h20 + 32'($urandom_range(0, 3) * 4), m_count + 32'($urandom_range(0, 30)));
                4: bus_write(BASE32 + 32'h40 + 32'($urandom_range(0, 3) * 4), 32'($urandom_range(0, 15)));
                5: bus_write(BASE32 + 32'h00, $urandom);
                6: begin
                    bus_read(BASE32 + 32'($urandom_range(0, 31) * 4), v, t, v8, t8);
                    e = model_read(address | (BASE32 & 32'h0) | (32'h0), h);
                    cycle();
                end
                7: begin
                    mem_read = 1'b1;
                    bus_write(BASE32 + 32'h20 + 32'($urandom_range(0, 3) * 4), m_count + 32'($urandom_range(0, 30)));
                    mem_read = 1'b0;
                end
                8: bus_write(32'hffff0000 + 32'($urandom_range(0, 31) * 4), $urandom);
                default: cycle();
            endcase
            checks++;
            if (irq32 !== (|(m_pend & m_en)) || pend32 !== m_pend) begin
                errors++; $display("FAIL random_state k=%0d got %b/%h exp %b/%h", k, irq32, pend32, |(m_pend & m_en), m_pend);
            end
            if (k % 7 == 0) begin
                logic [31:0] a;
                a = BASE32 + 32'($urandom_range(0, 31) * 4);
                bus_read(a, v, t, v8, t8);
                e = model_read(a, h);
                checks++;
                if (t !== h || (h && v !== e) || (!h && v !== 32'bz && v !== 32'h0)) begin
                    errors++; $display("FAIL random_read addr=%h got %h/%b exp %h/%b", a, v, t, e, h);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] v, v8; logic t, t8;
        apply_reset(2);
        repeat (5) cycle();
        bus_write(BASE8 + 32'h04, 32'h1);
        bus_write(BASE8 + 32'h20, 32'd2);
        for (int k = 0; k < 300 && m_count != 32'd255; k++) begin
            cycle();
            checks++; if (pend8[0] !== 1'b0) begin errors++; $display("FAIL wrap_first_lap count=%0d got %b exp 0", m_count, pend8[0]); end
        end
        bus_read(BASE8 + 32'h00, v, t, v8, t8);
        checks++; if (v8 !== 32'h0000_00ff || t8 !== 1'b1) begin errors++; $display("FAIL wrap_count_ff got %h exp 000000ff", v8); end
        cycle();
        bus_read(BASE8 + 32'h00, v, t, v8, t8);
        checks++; if (v8 !== 32'h0) begin errors++; $display("FAIL wrap_count_0 got %h exp 00000000", v8); end
        for (int k = 0; k < 10 && m_count != 32'd258; k++) cycle();
        checks++; if (pend8[0] !== 1'b0 || irq8 !== 1'b0) begin errors++; $display("FAIL wrap_pre_match got %b/%b exp 0/0", pend8[0], irq8); end
        cycle();
        checks++; if (pend8[0] !== 1'b1 || irq8 !== 1'b1) begin errors++; $display("FAIL wrap_match got %b/%b exp 1/1", pend8[0], irq8); end
        bus_read(BASE8 + 32'h7c, v, t, v8, t8);
        checks++; if (t8 !== 1'b0 || (v8 !== 32'bz && v8 !== 32'h0)) begin errors++; $display("FAIL unmapped_7c got %h/%b exp z/0", v8, t8); end
        bus_read(BASE8 + 32'h28, v, t, v8, t8);
        checks++; if (t8 !== 1'b0) begin errors++; $display("FAIL unimpl_channel got %b exp 0", t8); end
        bus_read(BASE8 + 32'h24, v, t, v8, t8);
        checks++; if (t8 !== 1'b1 || v8 !== 32'h0000_00ff) begin errors++; $display("FAIL compare1_w8 got %h/%b exp 000000ff/1", v8, t8); end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_masked();
        test_collision();
        test_back_to_back();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
